// File: rtl/poly_square_synth.sv
// poly_square_synth: a multi-channel square-wave tone generator.
// Each channel plays a note for a fixed number of audio ticks. A channel can
// hold one queued note, which it plays right after the current note with no
// gap. A registered mix output counts how many channels are currently high.
`timescale 1ns/1ps

module poly_square_synth #(
    parameter  int CHANNELS = 2,
    parameter  int PERIOD_W = 16,
    parameter  int DUR_W    = 16,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MIX_W    = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance_tick_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [CH_W-1:0]     cmd_channel_i,
    input  logic [PERIOD_W-1:0] cmd_half_period_i,
    input  logic [DUR_W-1:0]    cmd_duration_i,
    output logic [CHANNELS-1:0] audio_o,
    output logic [MIX_W-1:0]    mix_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] done_o
);

    // An all-zero channel record is the idle, silent, empty-queue state.
    // Stop commands and reset both rely on this encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    typedef struct packed {
        state_e              state;
        logic [PERIOD_W-1:0] hp;          // active note half period (0 = rest)
        logic [DUR_W-1:0]    rem;         // ticks left in the active note
        logic [PERIOD_W-1:0] phase;       // ticks spent in the current half cycle
        logic                audio;       // square output level
        logic                pend_valid;  // queued note present
        logic [PERIOD_W-1:0] pend_hp;
        logic [DUR_W-1:0]    pend_dur;
    } chan_t;

    chan_t               chan_q [CHANNELS];
    chan_t               chan_d [CHANNELS];
    logic [CHANNELS-1:0] done_q, done_d;
    logic [MIX_W-1:0]    mix_q, mix_d;

    logic                pend_sel;
    logic                cmd_accept;
    logic                cmd_is_stop;
    logic [CHANNELS-1:0] cmd_hit;

    // Command handshake: refuse only a note aimed at a channel whose queue is full.
    always_comb begin
        // NOTE: each variable driven here gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        pend_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmd_channel_i == CH_W'(c)) begin
                pend_sel = chan_q[c].pend_valid;
            end
        end
        // An out-of-range channel matches nothing above and is always accepted.
        cmd_ready_o = (cmd_duration_i == '0) || !pend_sel;
    end

    // Decode which channel, if any, an accepted command targets.
    always_comb begin
        cmd_accept  = cmd_valid_i && cmd_ready_o;
        cmd_is_stop = (cmd_duration_i == '0);
        cmd_hit     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cmd_hit[c] = cmd_accept && (cmd_channel_i == CH_W'(c));
        end
    end

    // Next-state logic for every channel: stop, note end, tick advance, queueing.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            chan_d[c] = chan_q[c];
            done_d[c] = 1'b0;

            if (cmd_hit[c] && cmd_is_stop) begin
                // A stop overrides any tick this cycle and drops the queue.
                chan_d[c] = '0;
            end else if (chan_q[c].state == ST_PLAY && advance_tick_i) begin
                if (chan_q[c].rem == DUR_W'(1)) begin
                    // Final tick: force silence, even if a toggle was due.
                    done_d[c]       = 1'b1;
                    chan_d[c].audio = 1'b0;
                    chan_d[c].phase = '0;
                    if (chan_q[c].pend_valid) begin
                        chan_d[c].hp         = chan_q[c].pend_hp;
                        chan_d[c].rem        = chan_q[c].pend_dur;
                        chan_d[c].pend_valid = 1'b0;
                        chan_d[c].pend_hp    = '0;
                        chan_d[c].pend_dur   = '0;
                    end else if (cmd_hit[c]) begin
                        // The queue is empty, so a note arriving now starts
                        // immediately, with no gap.
                        chan_d[c].hp  = cmd_half_period_i;
                        chan_d[c].rem = cmd_duration_i;
                    end else begin
                        chan_d[c].state = ST_IDLE;
                        chan_d[c].hp    = '0;
                        chan_d[c].rem   = '0;
                    end
                end else begin
                    chan_d[c].rem = chan_q[c].rem - DUR_W'(1);
                    if (chan_q[c].hp != '0) begin
                        if (chan_q[c].phase == chan_q[c].hp - PERIOD_W'(1)) begin
                            chan_d[c].phase = '0;
                            chan_d[c].audio = ~chan_q[c].audio;
                        end else begin
                            chan_d[c].phase = chan_q[c].phase + PERIOD_W'(1);
                        end
                    end
                    if (cmd_hit[c]) begin
                        chan_d[c].pend_valid = 1'b1;
                        chan_d[c].pend_hp    = cmd_half_period_i;
                        chan_d[c].pend_dur   = cmd_duration_i;
                    end
                end
            end else if (cmd_hit[c]) begin
                if (chan_q[c].state == ST_IDLE) begin
                    chan_d[c].state = ST_PLAY;
                    chan_d[c].hp    = cmd_half_period_i;
                    chan_d[c].rem   = cmd_duration_i;
                    chan_d[c].phase = '0;
                    chan_d[c].audio = 1'b0;
                end else begin
                    chan_d[c].pend_valid = 1'b1;
                    chan_d[c].pend_hp    = cmd_half_period_i;
                    chan_d[c].pend_dur   = cmd_duration_i;
                end
            end
        end
    end

    // Mix: count the channel outputs that are currently high. Registering the
    // result makes it lag the audio outputs by one cycle.
    always_comb begin
        mix_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mix_d = mix_d + MIX_W'(chan_q[c].audio);
        end
    end

    // State register: asynchronous reset clears every channel, the queue and the mix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every channel register is cleared, queued-note fields
            // included. These are a handful of flops, not a RAM, so resetting
            // them costs nothing and means no stale note can replay.
            for (int c = 0; c < CHANNELS; c++) begin
                chan_q[c] <= '0;
            end
            done_q <= '0;
            mix_q  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every register
            // updates from values sampled on the same edge.
            for (int c = 0; c < CHANNELS; c++) begin
                chan_q[c] <= chan_d[c];
            end
            done_q <= done_d;
            mix_q  <= mix_d;
        end
    end

    // Outputs are taken directly from the registered channel state.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            audio_o[c] = chan_q[c].audio;
            busy_o[c]  = (chan_q[c].state == ST_PLAY);
        end
        done_o = done_q;
        mix_o  = mix_q;
    end

endmodule

// File: tb/tb_poly_square_synth.sv
// Directed testbench for poly_square_synth, built with three channels so that
// channel index 3 is a real out-of-range value.
`timescale 1ns/1ps

module tb_poly_square_synth;

    localparam int CHANNELS = 3;
    localparam int PERIOD_W = 16;
    localparam int DUR_W    = 16;
    localparam int CH_W     = 2;
    localparam int MIX_W    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_channel;
    logic [PERIOD_W-1:0] cmd_hp;
    logic [DUR_W-1:0]    cmd_dur;
    logic [CHANNELS-1:0] audio;
    logic [MIX_W-1:0]    mix;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;

    int checks   = 0;
    int failures = 0;

    poly_square_synth #(
        .CHANNELS (CHANNELS),
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .advance_tick_i    (tick),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_channel_i     (cmd_channel),
        .cmd_half_period_i (cmd_hp),
        .cmd_duration_i    (cmd_dur),
        .audio_o           (audio),
        .mix_o             (mix),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then step 1 ns past it so outputs are settled.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Offer a command for one cycle. The caller chooses the tick level.
    task automatic send(input int c, input int h, input int d);
        cmd_valid   = 1'b1;
        cmd_channel = CH_W'(c);
        cmd_hp      = PERIOD_W'(h);
        cmd_dur     = DUR_W'(d);
        edge1();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_a;
        logic prev_a;
        int   dcount;

        rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0;
        cmd_channel = '0; cmd_hp = '0; cmd_dur = '0;
        edge1(); edge1();
        check("reset_audio", audio, 0);
        check("reset_busy",  busy,  0);
        check("reset_done",  done,  0);
        check("reset_mix",   mix,   0);
        rst = 1'b0;

        // hp=2, D=8: output high after ticks 2-3 and 6-7; done and idle at tick 8.
        send(0, 2, 8);
        check("t1_busy_after_accept",  busy,  3'b001);
        check("t1_audio_after_accept", audio, 3'b000);
        tick   = 1'b1;
        prev_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            edge1();
            exp_a = (i % 4 == 2) || (i % 4 == 3);
            check($sformatf("t1_audio_tick%0d", i), audio[0], exp_a);
            check($sformatf("t1_done_tick%0d", i),  done[0],  (i == 8));
            check($sformatf("t1_busy_tick%0d", i),  busy[0],  (i != 8));
            check($sformatf("t1_mix_tick%0d", i),   mix,      prev_a);
            prev_a = exp_a;
        end
        edge1();
        check("t1_done_one_cycle", done[0], 0);
        tick = 1'b0;

        // Queue: hp=3 D=6, then hp=1 D=4 queued. A third note to ch0 is refused.
        send(0, 3, 6);
        check("t2_busy", busy[0], 1);
        cmd_valid = 1'b1; cmd_channel = 2'd0; cmd_hp = 16'd1; cmd_dur = 16'd4;
        #1;
        check("t2_ready_pending_empty", cmd_ready, 1);
        edge1();
        #1;
        check("t2_ready_pending_full", cmd_ready, 0);
        cmd_channel = 2'd1;
        #1;
        check("t2_ready_other_channel", cmd_ready, 1);
        cmd_valid = 1'b0; cmd_channel = 2'd0;
        tick   = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 10; i++) begin
            edge1();
            exp_a = (i == 3) || (i == 4) || (i == 5) || (i == 7) || (i == 9);
            check($sformatf("t2_audio_tick%0d", i), audio[0], exp_a);
            check($sformatf("t2_done_tick%0d", i),  done[0],  (i == 6) || (i == 10));
            check($sformatf("t2_busy_tick%0d", i),  busy[0],  (i != 10));
            dcount += int'(done[0]);
        end
        check("t2_done_count", dcount, 2);
        tick = 1'b0;

        // Rest note: hp=0, D=5 stays silent but is busy for 5 ticks.
        send(0, 0, 5);
        tick   = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 5; i++) begin
            edge1();
            check($sformatf("t3_audio_tick%0d", i), audio[0], 0);
            check($sformatf("t3_busy_tick%0d", i),  busy[0],  (i != 5));
            dcount += int'(done[0]);
        end
        check("t3_done_count", dcount, 1);
        tick = 1'b0;

        // Stop while a note plays and the queue is full. Sent together with a
        // tick, the stop must take precedence over that tick.
        send(0, 2, 10);
        send(0, 1, 3);
        tick = 1'b1;
        edge1(); edge1();
        check("t4_audio_before_stop", audio[0], 1);
        cmd_valid = 1'b1; cmd_channel = 2'd0; cmd_hp = 16'd0; cmd_dur = 16'd0;
        #1;
        check("t4_stop_ready", cmd_ready, 1);
        edge1();
        cmd_valid = 1'b0;
        check("t4_busy_after_stop",  busy[0],  0);
        check("t4_audio_after_stop", audio[0], 0);
        check("t4_done_after_stop",  done[0],  0);
        for (int i = 1; i <= 4; i++) begin
            edge1();
            check($sformatf("t4_busy_idle%0d", i), busy[0], 0);
            check($sformatf("t4_done_idle%0d", i), done[0], 0);
        end
        cmd_channel = 2'd0; cmd_hp = 16'd1; cmd_dur = 16'd2;
        #1;
        check("t4_queue_cleared", cmd_ready, 1);
        tick = 1'b0;

        // Two channels in phase with hp=1; a command to channel 3 has no effect.
        send(0, 1, 6);
        send(1, 1, 6);
        cmd_valid = 1'b1; cmd_channel = 2'd3; cmd_hp = 16'd1; cmd_dur = 16'd2;
        #1;
        check("t5_oob_ready", cmd_ready, 1);
        edge1();
        cmd_valid = 1'b0;
        check("t5_oob_busy",  busy,  3'b011);
        check("t5_oob_audio", audio, 3'b000);
        tick = 1'b1;
        edge1();
        check("t5_audio_both", audio, 3'b011);
        check("t5_mix_lag",    mix,   0);
        tick = 1'b0;
        edge1();
        check("t5_audio_hold", audio, 3'b011);
        check("t5_mix_two",    mix,   2);

        // Asynchronous reset mid-note, with ticks gated off.
        #2 rst = 1'b1;
        #1;
        check("t6_async_audio", audio, 0);
        check("t6_async_busy",  busy,  0);
        check("t6_async_mix",   mix,   0);
        check("t6_async_done",  done,  0);
        edge1(); edge1(); edge1();
        rst = 1'b0;
        send(0, 2, 4);
        tick = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            edge1();
            check($sformatf("t6_audio_tick%0d", i), audio[0], (i == 2) || (i == 3));
            check($sformatf("t6_done_tick%0d", i),  done[0],  (i == 4));
        end
        tick = 1'b0;
        edge1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
